// File: rtl/e_mdu_pkg.sv
// Shared MDU definitions: operation encodings, default latencies and the
// behavioural arithmetic that produces a full HI/LO result in one step.
package e_mdu_pkg;

  typedef enum logic [3:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MTHI  = 4'd5,
    MDU_MTLO  = 4'd6,
    MDU_MFHI  = 4'd7,
    MDU_MFLO  = 4'd8
  } mdu_op_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        commit;  // result may be written to HI/LO at completion
  } mdu_res_t;

  function automatic mdu_res_t mdu_compute(input mdu_op_e op, input logic [31:0] a,
                                           input logic [31:0] b);
    mdu_res_t           res;
    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic signed [32:0] a_s, b_s, q_s, r_s;
    logic        [31:0] b_nz;
    res    = '0;
    b_nz   = (b == 32'd0) ? 32'd1 : b;
    // One extra bit keeps 0x80000000 / -1 representable; the low word wraps
    a_s    = {a[31], a};
    b_s    = {b_nz[31], b_nz};
    q_s    = a_s / b_s;
    r_s    = a_s % b_s;
    prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    prod_u = {32'd0, a} * {32'd0, b};
    case (op)
      MDU_MULT:  res = '{hi: prod_s[63:32], lo: prod_s[31:0], commit: 1'b1};
      MDU_MULTU: res = '{hi: prod_u[63:32], lo: prod_u[31:0], commit: 1'b1};
      MDU_DIV:   res = '{hi: r_s[31:0], lo: q_s[31:0], commit: (b != 32'd0)};
      MDU_DIVU:  res = '{hi: a % b_nz, lo: a / b_nz, commit: (b != 32'd0)};
      default:   res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: fixed-latency MULT/DIV with architectural
// HI/LO, MTHI/MTLO writes and combinational MFHI/MFLO reads.
module e_mdu
  import e_mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [3:0]  MDUOp,
  input  logic        Start,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDUOut
);

  mdu_op_e     op;
  mdu_res_t    res;
  logic [31:0] hi_q, hi_d, lo_q, lo_d, hi_tmp_q, hi_tmp_d, lo_tmp_q, lo_tmp_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d, commit_q, commit_d;

  assign op  = mdu_op_e'(MDUOp);
  assign res = mdu_compute(op, A, B);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    hi_d     = hi_q;
    lo_d     = lo_q;
    hi_tmp_d = hi_tmp_q;
    lo_tmp_d = lo_tmp_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    commit_d = commit_q;
    if (busy_q) begin
      // Start and MT* are deliberately ignored while an operation is in flight
      if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
      if (cnt_q == 4'd1) begin
        busy_d = 1'b0;
        if (commit_q) begin
          hi_d = hi_tmp_q;
          lo_d = lo_tmp_q;
        end
      end
    end else if (Start) begin
      if (op inside {MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU}) begin
        hi_tmp_d = res.hi;
        lo_tmp_d = res.lo;
        commit_d = res.commit;
        cnt_d    = (op inside {MDU_DIV, MDU_DIVU}) ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
        busy_d   = 1'b1;
      end
    end else begin
      case (op)
        MDU_MTHI: hi_d = A;
        MDU_MTLO: lo_d = A;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      hi_q     <= '0;
      lo_q     <= '0;
      hi_tmp_q <= '0;
      lo_tmp_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      commit_q <= 1'b0;
    end else begin
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      hi_tmp_q <= hi_tmp_d;
      lo_tmp_q <= lo_tmp_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      commit_q <= commit_d;
    end
  end

  always_comb begin
    MDUOut = '0;
    case (op)
      MDU_MFHI: MDUOut = hi_q;
      MDU_MFLO: MDUOut = lo_q;
      default:  ;
    endcase
  end

  assign Busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_e_mdu.sv
// Self-checking bench for e_mdu: directed scenarios plus random operations
// checked against a 64-bit arithmetic reference model of HI/LO.
module tb_e_mdu;
  import e_mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] A = '0, B = '0;
  logic [3:0]  MDUOp = 4'd0;
  logic        Start = 1'b0;
  logic        Busy;
  logic [31:0] HI, LO, MDUOut;

  int          total = 0;
  int          bad = 0;
  logic [31:0] hi_m = '0, lo_m = '0;

  e_mdu dut (
    .clk(clk), .reset(reset), .A(A), .B(B), .MDUOp(MDUOp), .Start(Start),
    .Busy(Busy), .HI(HI), .LO(LO), .MDUOut(MDUOut)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: plain 64-bit arithmetic on the architectural HI/LO
  task automatic model_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int cyc);
    longint          sa, sb, q, r, p;
    longint unsigned ua, ub, uq, ur, pu;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    cyc = 0;
    case (op)
      4'd1: begin p = sa * sb; hi_m = p[63:32]; lo_m = p[31:0]; cyc = 5; end
      4'd2: begin pu = ua * ub; hi_m = pu[63:32]; lo_m = pu[31:0]; cyc = 5; end
      4'd3: begin
        cyc = 10;
        if (b != 0) begin q = sa / sb; r = sa % sb; lo_m = q[31:0]; hi_m = r[31:0]; end
      end
      4'd4: begin
        cyc = 10;
        if (b != 0) begin uq = ua / ub; ur = ua % ub; lo_m = uq[31:0]; hi_m = ur[31:0]; end
      end
      4'd5: hi_m = a;
      4'd6: lo_m = a;
      default: ;
    endcase
  endtask

  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input string name);
    int          cyc, n;
    logic [31:0] hp, lp;
    hp = hi_m;
    lp = lo_m;
    model_op(op, a, b, cyc);
    A = a; B = b; MDUOp = op; Start = (cyc != 0);
    step();
    Start = 1'b0; MDUOp = 4'd0;
    if (cyc != 0) begin
      total++;
      if (Busy !== 1'b1 || HI !== hp || LO !== lp) begin
        bad++;
        $display("FAIL %s early: busy=%b hi=%h lo=%h, want busy=1 hi=%h lo=%h",
                 name, Busy, HI, LO, hp, lp);
      end
      n = 0;
      while (Busy === 1'b1 && n < 40) begin n++; step(); end
      total++;
      if (n != cyc) begin
        bad++;
        $display("FAIL %s busy_cycles: got %0d want %0d", name, n, cyc);
      end
    end
    total++;
    if (Busy !== 1'b0 || HI !== hi_m || LO !== lo_m) begin
      bad++;
      $display("FAIL %s result: busy=%b hi=%h lo=%h, want busy=0 hi=%h lo=%h",
               name, Busy, HI, LO, hi_m, lo_m);
    end
    MDUOp = 4'd7; #1;
    total++;
    if (MDUOut !== hi_m) begin bad++; $display("FAIL %s mfhi: got %h want %h", name, MDUOut, hi_m); end
    MDUOp = 4'd8; #1;
    total++;
    if (MDUOut !== lo_m) begin bad++; $display("FAIL %s mflo: got %h want %h", name, MDUOut, lo_m); end
    MDUOp = 4'd0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    hi_m = '0; lo_m = '0;
    MDUOp = 4'd7; #1;
    total++;
    if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0 || MDUOut !== 32'd0) begin
      bad++;
      $display("FAIL reset: busy=%b hi=%h lo=%h out=%h, want all zero", Busy, HI, LO, MDUOut);
    end
    MDUOp = 4'd0;
  endtask

  task automatic test_mult();
    do_op(4'd1, 32'hFFFF_FFFE, 32'd3, "mult_neg2x3");
    total++;
    if (HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFFA) begin
      bad++; $display("FAIL mult_const: hi=%h lo=%h want ffffffff fffffffa", HI, LO);
    end
    do_op(4'd2, 32'hFFFF_FFFE, 32'd3, "multu_big");
    total++;
    if (HI !== 32'h0000_0002 || LO !== 32'hFFFF_FFFA) begin
      bad++; $display("FAIL multu_const: hi=%h lo=%h want 00000002 fffffffa", HI, LO);
    end
  endtask

  task automatic test_div();
    do_op(4'd3, -32'sd7, 32'd2, "div_m7_2");
    total++;
    if (HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFFD) begin
      bad++; $display("FAIL div_const: hi=%h lo=%h want ffffffff fffffffd", HI, LO);
    end
    do_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, "div_overflow");
    do_op(4'd4, 32'hFFFF_FFF0, 32'd7, "divu_big");
  endtask

  task automatic test_div_by_zero();
    do_op(4'd5, 32'h1234, 32'd0, "mthi");
    do_op(4'd6, 32'h5678, 32'd0, "mtlo");
    do_op(4'd4, 32'd7, 32'd0, "divu_zero");
    total++;
    if (HI !== 32'h1234 || LO !== 32'h5678) begin
      bad++; $display("FAIL divu_zero_const: hi=%h lo=%h want 00001234 00005678", HI, LO);
    end
    do_op(4'd3, 32'hFFFF_0000, 32'd0, "div_zero");
  endtask

  task automatic test_reset_mid_op();
    do_op(4'd5, 32'hAAAA, 32'd0, "mthi_aaaa");
    A = 32'd3; B = 32'd5; MDUOp = 4'd1; Start = 1'b1;
    step();
    Start = 1'b0; MDUOp = 4'd0;
    step(); step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    hi_m = '0; lo_m = '0;
    total++;
    if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
      bad++; $display("FAIL reset_abort: busy=%b hi=%h lo=%h want 0 0 0", Busy, HI, LO);
    end
    repeat (8) step();
    total++;
    if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
      bad++; $display("FAIL reset_no_late_update: busy=%b hi=%h lo=%h want 0 0 0", Busy, HI, LO);
    end
  endtask

  task automatic test_start_while_busy();
    int cyc, n;
    model_op(4'd3, 32'd100, 32'd7, cyc);
    A = 32'd100; B = 32'd7; MDUOp = 4'd3; Start = 1'b1;
    step();
    n = 0;
    while (Busy === 1'b1 && n < 40) begin
      n++;
      if (n == 1) begin A = 32'd2; B = 32'd2; MDUOp = 4'd1; Start = 1'b1; end
      else if (n == 2) begin A = 32'hDEAD; Start = 1'b0; MDUOp = 4'd5; end
      else begin Start = 1'b0; MDUOp = 4'd0; end
      step();
    end
    total++;
    if (n != cyc) begin bad++; $display("FAIL busy_ignore_cycles: got %0d want %0d", n, cyc); end
    MDUOp = 4'd8; #1;
    total++;
    if (MDUOut !== lo_m) begin bad++; $display("FAIL busy_ignore_mflo: got %h want %h", MDUOut, lo_m); end
    MDUOp = 4'd7; #1;
    total++;
    if (MDUOut !== hi_m) begin bad++; $display("FAIL busy_ignore_mfhi: got %h want %h", MDUOut, hi_m); end
    MDUOp = 4'd0;
  endtask

  task automatic test_undefined_ops();
    for (int op = 9; op < 16; op++) begin
      A = $urandom; MDUOp = 4'(op); Start = 1'b0;
      step();
      total++;
      if (Busy !== 1'b0 || HI !== hi_m || LO !== lo_m || MDUOut !== 32'd0) begin
        bad++;
        $display("FAIL undef_op_%0d: busy=%b hi=%h lo=%h out=%h want 0 %h %h 0",
                 op, Busy, HI, LO, MDUOut, hi_m, lo_m);
      end
    end
    MDUOp = 4'd0;
  endtask

  task automatic test_random();
    logic [3:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 30; i++) begin
      op = 4'($urandom_range(1, 6));
      a  = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 20);
        2:       b = -32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      do_op(op, a, b, $sformatf("rand_%0d_op%0d", i, op));
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_by_zero();
    test_reset_mid_op();
    test_start_while_busy();
    test_undefined_ops();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
